// File: rtl/bcd_time_counter.sv
// bcd_time_counter: HH:MM:SS time-of-day counter with six BCD digit outputs.
// Advances on a 1 Hz enable pulse. A three-state set-mode FSM lets the user
// step hours and minutes with two pre-debounced button pulses, and blinks
// the selected field on the tick. Every output comes straight from a flop.
module bcd_time_counter #(
  parameter bit HOUR_24 = 1'b1  // 1 = 00..23, 0 = 01..12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] hr_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] min_tens,
  output logic [3:0] min_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic       blank_hr,
  output logic       blank_min,
  output logic       set_active,
  output logic       day_pulse
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_SET_HR  = 2'd1,
    ST_SET_MIN = 2'd2
  } state_t;

  // Midnight in 24 h mode, noon-style 12:00 in 12 h mode.
  localparam logic [3:0] HR_TENS_RST = HOUR_24 ? 4'd0 : 4'd1;
  localparam logic [3:0] HR_ONES_RST = HOUR_24 ? 4'd0 : 4'd2;

  state_t     r_state, w_state_next;
  logic       r_phase, w_phase_next;
  logic [3:0] r_hr_tens, r_hr_ones, r_min_tens, r_min_ones, r_sec_tens, r_sec_ones;
  logic [3:0] w_hr_tens_next, w_hr_ones_next;
  logic [3:0] w_min_tens_next, w_min_ones_next;
  logic [3:0] w_sec_tens_next, w_sec_ones_next;
  logic       w_day_next;
  logic       r_blank_hr, r_blank_min, r_set_active, r_day_pulse;

  logic       w_sec_wrap, w_min_wrap, w_hr_day;
  logic [7:0] w_hr_inc, w_min_inc, w_sec_inc;

  // Two-digit 0..59 BCD increment, wrapping 59 -> 00.
  function automatic logic [7:0] inc_60(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] res;
    if (ones == 4'd9) begin
      res = {(tens == 4'd5) ? 4'd0 : tens + 4'd1, 4'd0};
    end else begin
      res = {tens, ones + 4'd1};
    end
    return res;
  endfunction

  // Two-digit hour BCD increment with format-dependent wrap.
  function automatic logic [7:0] inc_hr(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] res;
    if (HOUR_24 && tens == 4'd2 && ones == 4'd3) begin
      res = {4'd0, 4'd0};
    end else if (!HOUR_24 && tens == 4'd1 && ones == 4'd2) begin
      res = {4'd0, 4'd1};
    end else if (ones == 4'd9) begin
      res = {tens + 4'd1, 4'd0};
    end else begin
      res = {tens, ones + 4'd1};
    end
    return res;
  endfunction

  // Carry / rollover detection and the candidate incremented fields.
  always_comb begin
    w_sec_wrap = (r_sec_tens == 4'd5) && (r_sec_ones == 4'd9);
    w_min_wrap = (r_min_tens == 4'd5) && (r_min_ones == 4'd9);
    // Day rollover: 23 -> 00 in 24 h mode, 11 -> 12 in 12 h mode.
    w_hr_day   = HOUR_24 ? ((r_hr_tens == 4'd2) && (r_hr_ones == 4'd3))
                         : ((r_hr_tens == 4'd1) && (r_hr_ones == 4'd1));
    w_sec_inc  = inc_60(r_sec_tens, r_sec_ones);
    w_min_inc  = inc_60(r_min_tens, r_min_ones);
    w_hr_inc   = inc_hr(r_hr_tens, r_hr_ones);
  end

  // Next state, blink phase and time fields for the coming edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned,
    // which would otherwise infer a latch.
    w_state_next    = r_state;
    w_phase_next    = r_phase;
    w_hr_tens_next  = r_hr_tens;
    w_hr_ones_next  = r_hr_ones;
    w_min_tens_next = r_min_tens;
    w_min_ones_next = r_min_ones;
    w_sec_tens_next = r_sec_tens;
    w_sec_ones_next = r_sec_ones;
    w_day_next      = 1'b0;

    unique case (r_state)
      ST_RUN: begin
        w_phase_next = 1'b0;
        if (tick_1hz) begin
          {w_sec_tens_next, w_sec_ones_next} = w_sec_inc;
          if (w_sec_wrap) begin
            {w_min_tens_next, w_min_ones_next} = w_min_inc;
            if (w_min_wrap) begin
              {w_hr_tens_next, w_hr_ones_next} = w_hr_inc;
              w_day_next = w_hr_day;
            end
          end
        end
        // A coincident tick is still applied above; only the state moves.
        if (btn_mode) begin
          w_state_next = ST_SET_HR;
        end
      end

      ST_SET_HR: begin
        if (tick_1hz) w_phase_next = ~r_phase;
        if (btn_mode) begin
          w_state_next = ST_SET_MIN;
          w_phase_next = 1'b0;
        end else if (btn_inc) begin
          {w_hr_tens_next, w_hr_ones_next} = w_hr_inc;
        end
      end

      ST_SET_MIN: begin
        if (tick_1hz) w_phase_next = ~r_phase;
        if (btn_mode) begin
          w_state_next    = ST_RUN;
          w_phase_next    = 1'b0;
          w_sec_tens_next = 4'd0;
          w_sec_ones_next = 4'd0;
        end else if (btn_inc) begin
          {w_min_tens_next, w_min_ones_next} = w_min_inc;
        end
      end

      default: begin
        w_state_next = ST_RUN;
        w_phase_next = 1'b0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_next;
  end

  // Time digits, blink phase and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase      <= 1'b0;
      r_hr_tens    <= HR_TENS_RST;
      r_hr_ones    <= HR_ONES_RST;
      r_min_tens   <= 4'd0;
      r_min_ones   <= 4'd0;
      r_sec_tens   <= 4'd0;
      r_sec_ones   <= 4'd0;
      r_blank_hr   <= 1'b0;
      r_blank_min  <= 1'b0;
      r_set_active <= 1'b0;
      r_day_pulse  <= 1'b0;
    end else begin
      r_phase      <= w_phase_next;
      r_hr_tens    <= w_hr_tens_next;
      r_hr_ones    <= w_hr_ones_next;
      r_min_tens   <= w_min_tens_next;
      r_min_ones   <= w_min_ones_next;
      r_sec_tens   <= w_sec_tens_next;
      r_sec_ones   <= w_sec_ones_next;
      r_blank_hr   <= (w_state_next == ST_SET_HR)  && w_phase_next;
      r_blank_min  <= (w_state_next == ST_SET_MIN) && w_phase_next;
      r_set_active <= (w_state_next != ST_RUN);
      r_day_pulse  <= w_day_next;
    end
  end

  assign hr_tens    = r_hr_tens;
  assign hr_ones    = r_hr_ones;
  assign min_tens   = r_min_tens;
  assign min_ones   = r_min_ones;
  assign sec_tens   = r_sec_tens;
  assign sec_ones   = r_sec_ones;
  assign blank_hr   = r_blank_hr;
  assign blank_min  = r_blank_min;
  assign set_active = r_set_active;
  assign day_pulse  = r_day_pulse;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter. A 24 h and a 12 h instance share
// the same stimulus; each is compared every cycle against an integer
// hours/minutes/seconds reference model, plus constant expectations from a
// vector table and directed corner-case sequences.
module tb_bcd_time_counter;

  logic clk = 1'b0;
  logic rst = 1'b0, tick = 1'b0, mode = 1'b0, inc = 1'b0;

  logic [3:0] a_ht, a_ho, a_mt, a_mo, a_st, a_so;
  logic       a_bh, a_bm, a_sa, a_dp;
  logic [3:0] b_ht, b_ho, b_mt, b_mo, b_st, b_so;
  logic       b_bh, b_bm, b_sa, b_dp;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model, index 1 = 24 h, 0 = 12 h. State: 0 run, 1 set hours, 2 set minutes.
  int mh[2], mm[2], ms[2], mst[2];
  bit mph[2], mdp[2];

  always #5 clk = ~clk;

  bcd_time_counter #(.HOUR_24(1'b1)) u_dut24 (
    .clk(clk), .rst(rst), .tick_1hz(tick), .btn_mode(mode), .btn_inc(inc),
    .hr_tens(a_ht), .hr_ones(a_ho), .min_tens(a_mt), .min_ones(a_mo),
    .sec_tens(a_st), .sec_ones(a_so), .blank_hr(a_bh), .blank_min(a_bm),
    .set_active(a_sa), .day_pulse(a_dp)
  );

  bcd_time_counter #(.HOUR_24(1'b0)) u_dut12 (
    .clk(clk), .rst(rst), .tick_1hz(tick), .btn_mode(mode), .btn_inc(inc),
    .hr_tens(b_ht), .hr_ones(b_ho), .min_tens(b_mt), .min_ones(b_mo),
    .sec_tens(b_st), .sec_ones(b_so), .blank_hr(b_bh), .blank_min(b_bm),
    .set_active(b_sa), .day_pulse(b_dp)
  );

  function automatic logic [27:0] pack(int hh, int mi, int ss, bit sa, bit bh, bit bm, bit dp);
    logic [3:0] d[6];
    d[0] = 4'(hh / 10); d[1] = 4'(hh % 10);
    d[2] = 4'(mi / 10); d[3] = 4'(mi % 10);
    d[4] = 4'(ss / 10); d[5] = 4'(ss % 10);
    return {d[0], d[1], d[2], d[3], d[4], d[5], sa, bh, bm, dp};
  endfunction

  function automatic logic [27:0] act24();
    return {a_ht, a_ho, a_mt, a_mo, a_st, a_so, a_sa, a_bh, a_bm, a_dp};
  endfunction

  function automatic logic [27:0] act12();
    return {b_ht, b_ho, b_mt, b_mo, b_st, b_so, b_sa, b_bh, b_bm, b_dp};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got HHMMSS/flags %h_%b, expected %h_%b",
               name, act[27:4], act[3:0], exp[27:4], exp[3:0]);
    end
  endtask

  task automatic model_step(input int f, input bit r, input bit t, input bit mo, input bit i);
    if (r) begin
      mh[f] = f ? 0 : 12; mm[f] = 0; ms[f] = 0; mst[f] = 0; mph[f] = 0; mdp[f] = 0;
    end else begin
      mdp[f] = 0;
      if (mst[f] == 0) begin
        if (t) begin
          ms[f]++;
          if (ms[f] == 60) begin
            ms[f] = 0; mm[f]++;
            if (mm[f] == 60) begin
              mm[f] = 0;
              if (f == 1) begin mh[f] = (mh[f] + 1) % 24; mdp[f] = (mh[f] == 0);  end
              else        begin mh[f] = mh[f] % 12 + 1;   mdp[f] = (mh[f] == 12); end
            end
          end
        end
        if (mo) begin mst[f] = 1; mph[f] = 0; end
      end else begin
        if (t) mph[f] = ~mph[f];
        if (mo) begin
          if (mst[f] == 2) ms[f] = 0;
          mst[f] = (mst[f] + 1) % 3;
          mph[f] = 0;
        end else if (i) begin
          if (mst[f] == 1) mh[f] = (f == 1) ? (mh[f] + 1) % 24 : mh[f] % 12 + 1;
          else             mm[f] = (mm[f] + 1) % 60;
        end
      end
    end
  endtask

  function automatic logic [27:0] model_exp(input int f);
    return pack(mh[f], mm[f], ms[f], mst[f] != 0, mst[f] == 1 && mph[f],
                mst[f] == 2 && mph[f], mdp[f]);
  endfunction

  // One clock: drive inputs, take the edge, advance the models, compare #1 later.
  task automatic step(input bit r, input bit t, input bit mo, input bit i);
    rst = r; tick = t; mode = mo; inc = i;
    @(posedge clk);
    model_step(1, r, t, mo, i);
    model_step(0, r, t, mo, i);
    #1;
    check("model24", act24(), model_exp(1));
    check("model12", act12(), model_exp(0));
  endtask

  task automatic repeat_step(input int n, input bit t, input bit mo, input bit i);
    for (int k = 0; k < n; k++) step(1'b0, t, mo, i);
  endtask

  typedef struct {
    bit r, t, m, i;
    int hh, mi, ss;
    bit sa, bh, bm, dp;
  } vec_t;

  vec_t vecs[14];
  bit   seen_dp;

  initial begin
    // r  t  m  i   hh mm ss  sa bh bm dp   (24 h instance)
    vecs[0]  = '{1,0,0,0,  0, 0, 0, 0,0,0,0};
    vecs[1]  = '{0,1,0,0,  0, 0, 1, 0,0,0,0};
    vecs[2]  = '{0,0,1,1,  0, 0, 1, 1,0,0,0};
    vecs[3]  = '{0,0,0,1,  1, 0, 1, 1,0,0,0};
    vecs[4]  = '{0,1,0,0,  1, 0, 1, 1,1,0,0};
    vecs[5]  = '{0,1,0,1,  2, 0, 1, 1,0,0,0};
    vecs[6]  = '{0,0,1,1,  2, 0, 1, 1,0,0,0};
    vecs[7]  = '{0,1,0,0,  2, 0, 1, 1,0,1,0};
    vecs[8]  = '{0,1,0,1,  2, 1, 1, 1,0,0,0};
    vecs[9]  = '{0,1,0,0,  2, 1, 1, 1,0,1,0};
    vecs[10] = '{0,1,1,0,  2, 1, 0, 0,0,0,0};
    vecs[11] = '{0,1,0,0,  2, 1, 1, 0,0,0,0};
    vecs[12] = '{0,1,0,1,  2, 1, 2, 0,0,0,0};
    vecs[13] = '{1,1,1,0,  0, 0, 0, 0,0,0,0};

    @(negedge clk);
    for (int v = 0; v < 14; v++) begin
      step(vecs[v].r, vecs[v].t, vecs[v].m, vecs[v].i);
      check($sformatf("vec%0d", v), act24(),
            pack(vecs[v].hh, vecs[v].mi, vecs[v].ss, vecs[v].sa, vecs[v].bh, vecs[v].bm, vecs[v].dp));
    end

    // Reset state of both formats, then 59/60 ticks with no day pulse.
    step(1, 0, 0, 0);
    check("reset24", act24(), pack(0, 0, 0, 0, 0, 0, 0));
    check("reset12", act12(), pack(12, 0, 0, 0, 0, 0, 0));
    seen_dp = 0;
    for (int k = 0; k < 59; k++) begin
      step(0, 1, 0, 0);
      seen_dp |= a_dp;
    end
    check("sec59", act24(), pack(0, 0, 59, 0, 0, 0, 0));
    step(0, 1, 0, 0);
    seen_dp |= a_dp;
    check("min_carry", act24(), pack(0, 1, 0, 0, 0, 0, 0));
    check("no_day_pulse", {27'd0, seen_dp}, 28'd0);

    // Preload 23:59:58 in 24 h mode, then roll over the day.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0); repeat_step(23, 0, 0, 1);
    step(0, 0, 1, 0); repeat_step(59, 0, 0, 1);
    step(0, 0, 1, 0); repeat_step(58, 1, 0, 0);
    check("pre_235958", act24(), pack(23, 59, 58, 0, 0, 0, 0));
    step(0, 1, 0, 0);
    check("t_235959", act24(), pack(23, 59, 59, 0, 0, 0, 0));
    step(0, 1, 0, 0);
    check("day_roll24", act24(), pack(0, 0, 0, 0, 0, 0, 1));
    step(0, 0, 0, 0);
    check("day_pulse_one_cycle", act24(), pack(0, 0, 0, 0, 0, 0, 0));

    // 12 h: 11:59:59 -> 12:00:00 with day pulse; 12:59:59 -> 01:00:00 without.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0); repeat_step(11, 0, 0, 1);
    step(0, 0, 1, 0); repeat_step(59, 0, 0, 1);
    step(0, 0, 1, 0); repeat_step(59, 1, 0, 0);
    check("pre_115959", act12(), pack(11, 59, 59, 0, 0, 0, 0));
    step(0, 1, 0, 0);
    check("noon12", act12(), pack(12, 0, 0, 0, 0, 0, 1));
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    repeat_step(59, 0, 0, 1);
    step(0, 0, 1, 0); repeat_step(59, 1, 0, 0);
    check("pre_125959", act12(), pack(12, 59, 59, 0, 0, 0, 0));
    step(0, 1, 0, 0);
    check("wrap12_to_01", act12(), pack(1, 0, 0, 0, 0, 0, 0));

    // Set mode: hours wrap after 25 incs, minutes after 61, seconds clear on exit.
    step(1, 0, 0, 0); repeat_step(5, 1, 0, 0);
    step(0, 0, 1, 0);
    check("enter_set", act24(), pack(0, 0, 5, 1, 0, 0, 0));
    step(0, 1, 0, 0);
    check("blink_hr", act24(), pack(0, 0, 5, 1, 1, 0, 0));
    repeat_step(25, 0, 0, 1);
    check("hr_wrap_25", act24(), pack(1, 0, 5, 1, 1, 0, 0));
    step(0, 0, 1, 0); repeat_step(61, 0, 0, 1);
    check("min_wrap_61", act24(), pack(1, 1, 5, 1, 0, 0, 0));
    step(0, 1, 0, 0);
    check("blink_min", act24(), pack(1, 1, 5, 1, 0, 1, 0));
    step(0, 0, 1, 0);
    check("exit_set", act24(), pack(1, 1, 0, 0, 0, 0, 0));

    // Simultaneous events.
    step(1, 0, 0, 0); step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    check("mode_beats_inc", act24(), pack(0, 0, 0, 1, 0, 0, 0));
    step(1, 0, 0, 0); repeat_step(9, 1, 0, 0);
    step(0, 1, 1, 0);
    check("tick_and_mode", act24(), pack(0, 0, 10, 1, 0, 0, 0));

    // Reset mid SET_MIN at 07:42:13, with a coincident tick.
    step(1, 0, 0, 0); repeat_step(13, 1, 0, 0);
    step(0, 0, 1, 0); repeat_step(7, 0, 0, 1);
    step(0, 0, 1, 0); repeat_step(42, 0, 0, 1);
    step(0, 1, 0, 0);
    check("pre_074213", act24(), pack(7, 42, 13, 1, 0, 1, 0));
    step(1, 1, 0, 0);
    check("rst_in_set", act24(), pack(0, 0, 0, 0, 0, 0, 0));

    // Randomized traffic: a button-heavy phase, then a tick-heavy one.
    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    for (int k = 0; k < 6000; k++)
      step($urandom_range(0, 4999) == 0, $urandom_range(0, 9) != 0,
           $urandom_range(0, 299) == 0, $urandom_range(0, 1) == 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
Time-of-day counter that produces the six BCD digits (HH:MM:SS) driven into the per-digit 7-segment decoders. It advances on a 1 Hz enable pulse and includes a small set-mode FSM that lets the user adjust hours and minutes with two pre-debounced button pulses. All outputs are registered. Each digit output feeds one 7-segment decoder instance directly; the decoder blanks any value above 9.

Parameters:
HOUR_24, 1, 1 = 24-hour format (00..23); 0 = 12-hour format (01..12).

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
tick_1hz  input  1  one-cycle enable pulse, once per second
btn_mode  input  1  one-cycle pulse (debounced upstream); advances the set-mode FSM
btn_inc  input  1  one-cycle pulse (debounced upstream); increments the selected field in set mode
hr_tens  output  4  BCD hours tens digit
hr_ones  output  4  BCD hours ones digit
min_tens  output  4  BCD minutes tens digit
min_ones  output  4  BCD minutes ones digit
sec_tens  output  4  BCD seconds tens digit
sec_ones  output  4  BCD seconds ones digit
blank_hr  output  1  1 = display blanks both hour digits (blink phase)
blank_min  output  1  1 = display blanks both minute digits (blink phase)
set_active  output  1  1 while in SET_HR or SET_MIN
day_pulse  output  1  one-cycle pulse on day rollover

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - Time = 00:00:00 if HOUR_24=1; 12:00:00 if HOUR_24=0.
  - state = RUN; blank_hr = blank_min = set_active = day_pulse = 0; blink phase = 0.
  - Reset overrides all other inputs in that cycle, including mid-set or mid-rollover.
- Digit invariant: every digit stays legal BCD at all times.
  - sec_tens and min_tens: 0..5; sec_ones and min_ones: 0..9.
  - Hours: legal for the selected format; hr_tens ≤ 2.
- FSM states: RUN, SET_HR, SET_MIN.
  - RUN --btn_mode--> SET_HR --btn_mode--> SET_MIN --btn_mode--> RUN.
  - On the SET_MIN→RUN transition, seconds clear to 00 in that same edge.
- RUN behaviour:
  - Each tick_1hz increments seconds with BCD carry: ss 59→00 carries to minutes; mm 59→00 carries to hours.
  - 24h: hours 23→00, asserting day_pulse for exactly one cycle.
  - 12h: hours 12→01; 11:59:59→12:00:00 asserts day_pulse (once per 12 h).
  - btn_inc is ignored.
- Set-state behaviour:
  - Time does not advance; tick_1hz only toggles the blink phase.
  - SET_HR: btn_inc increments hours with wrap (24h: 23→00; 12h: 12→01). No carry, no day_pulse.
  - SET_MIN: btn_inc increments minutes 59→00, no carry into hours. Seconds hold.
- Blink outputs:
  - blank_hr = (state==SET_HR) & phase; blank_min = (state==SET_MIN) & phase.
  - Phase clears to 0 on every state change, so a newly selected field starts visible.
- Latency: outputs reflect an event one clk after the sampling edge (registered). Only the tick edge where a carry occurs can change multiple fields.
- Simultaneous events:
  - btn_mode & btn_inc in the same cycle: btn_mode wins; inc is dropped.
  - tick_1hz & btn_mode in RUN: the tick is applied (including any carry and day_pulse) and state goes to SET_HR on the same edge.
  - tick_1hz & btn_inc in a set state: the increment is applied and the phase toggles.
  - tick_1hz during rst: ignored.
- Pulse inputs held high for N cycles act as N events; no edge detection is done here.

Test Plan:
- Reset, then 59 ticks → 00:00:59; 1 more tick → 00:01:00. day_pulse stays 0 throughout.
- Preload to 23:59:58 via set mode (24h); 2 ticks → 23:59:59 then 00:00:00. day_pulse high for exactly the one cycle after the second tick.
- HOUR_24=0: after reset, reads 12:00:00. Set to 11:59:59 and tick → 12:00:00 with day_pulse=1. Set to 12:59:59 and tick → 01:00:00 with day_pulse=0.
- Set mode: btn_mode → set_active=1; 25 btn_inc pulses in SET_HR → hours 01 (24h wrap). btn_mode, then 61 btn_inc pulses → minutes 01, hours unchanged. btn_mode → RUN with seconds 00. Ticks during set mode toggle blank_hr/blank_min but leave the time unchanged.
- Same-cycle btn_mode+btn_inc in SET_HR → state SET_MIN, hours unchanged. Same-cycle tick+btn_mode at 00:00:09 in RUN → 00:00:10 and SET_HR.
- Assert rst while in SET_MIN with time 07:42:13 → next cycle reads 00:00:00 (24h), RUN, all flags 0. A tick coincident with rst has no effect.
